// File: rtl/regfile_pkg.sv
// Shared register-file constants and writeback-arbiter state encoding.
package regfile_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;

    typedef enum logic [0:0] {
        NORMAL  = 1'b0,
        FORCE_M = 1'b1
    } wb_arb_state_t;

endpackage

// File: rtl/wb_starve_ctr.sv
// Saturating count of stalled multi-cycle cycles; hit flags the current count, hit_next the post-edge count.
// Purely registered count, no backpressure of its own.
module wb_starve_ctr #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic inc,
    input  logic clr,
    output logic hit,
    output logic hit_next
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && cnt_q != MAX_CNT) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit      = (cnt_q == MAX_CNT);
    assign hit_next = (cnt_d == MAX_CNT);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter, pipeline vs multi-cycle unit; WB_STALL_STATS_EN adds stall_cnt.
// Winning write appears one cycle after the transfer; readies are combinational, m forced after MAX_WAIT stalls.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DW       = REG_DW,
    parameter int AW       = REG_AW,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          p_valid,
    input  logic [AW-1:0] p_regW,
    input  logic [DW-1:0] p_dat,
    output logic          p_ready,
    input  logic          m_valid,
    input  logic [AW-1:0] m_regW,
    input  logic [DW-1:0] m_dat,
    output logic          m_ready,
    output logic          RegWrite,
    output logic [AW-1:0] regW,
    output logic [DW-1:0] Wdat
`ifdef WB_STALL_STATS_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    wb_arb_state_t state_q, state_d;
    logic          p_xfer, m_xfer;
    logic          hit, hit_next;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_dat;
    logic          regwrite_q;
    logic [AW-1:0] regw_q;
    logic [DW-1:0] wdat_q;

    // Readies held low during reset so nothing is consumed before the block is live.
    always_comb begin
        p_ready = 1'b0;
        m_ready = 1'b0;
        if (resetn) begin
            case (state_q)
                NORMAL: begin
                    p_ready = 1'b1;
                    m_ready = !p_valid || (m_valid && m_regW == p_regW);
                end
                FORCE_M: begin
                    m_ready = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign p_xfer = p_valid && p_ready;
    assign m_xfer = m_valid && m_ready;

    wb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk      (clk),
        .resetn   (resetn),
        .inc      (m_valid && !m_ready),
        .clr      (m_xfer),
        .hit      (hit),
        .hit_next (hit_next)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            NORMAL:  if (hit || hit_next) state_d = FORCE_M;
            FORCE_M: if (m_xfer) state_d = NORMAL;
            default: state_d = NORMAL;
        endcase
    end

    // Pipeline wins the mux; on a WAW squash both transfer but only p is written.
    assign wr_addr = p_xfer ? p_regW : m_regW;
    assign wr_dat  = p_xfer ? p_dat  : m_dat;
    assign wr_en   = (p_xfer || m_xfer) && (wr_addr != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= NORMAL;
            regwrite_q <= 1'b0;
            regw_q     <= '0;
            wdat_q     <= '0;
        end else begin
            state_q    <= state_d;
            regwrite_q <= wr_en;
            if (wr_en) begin
                regw_q <= wr_addr;
                wdat_q <= wr_dat;
            end
        end
    end

    assign RegWrite = regwrite_q;
    assign regW     = regw_q;
    assign Wdat     = wdat_q;

`ifdef WB_STALL_STATS_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
        end else if (p_valid && !p_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboarded bench for regfile_wb_arbiter: expected writes queued at handshake, checked when RegWrite fires.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        p_valid, m_valid;
    logic [4:0]  p_regW, m_regW;
    logic [31:0] p_dat, m_dat;
    logic        p_ready, m_ready;
    logic        RegWrite;
    logic [4:0]  regW;
    logic [31:0] Wdat;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    regfile_wb_arbiter #(.DW(32), .AW(5), .MAX_WAIT(4)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .p_valid  (p_valid),
        .p_regW   (p_regW),
        .p_dat    (p_dat),
        .p_ready  (p_ready),
        .m_valid  (m_valid),
        .m_regW   (m_regW),
        .m_dat    (m_dat),
        .m_ready  (m_ready),
        .RegWrite (RegWrite),
        .regW     (regW),
        .Wdat     (Wdat)
    );

    always #5 clk = ~clk;

    // Every issued write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        wr_t e;
        if (resetn === 1'b1 && RegWrite === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got r%0d=%h, required no write", regW, Wdat);
            end else begin
                e = exp_q.pop_front();
                if (regW !== e.a || Wdat !== e.d) begin
                    bad++;
                    $display("FAIL write_data: got r%0d=%h, required r%0d=%h", regW, Wdat, e.a, e.d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        resetn  = 1'b1;
        p_valid = 1'b0; p_regW = '0; p_dat = '0;
        m_valid = 1'b0; m_regW = '0; m_dat = '0;
        #2;
        resetn  = 1'b0;
        p_valid = 1'b1; p_regW = 5'd3; p_dat = 32'h33;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (RegWrite !== 1'b0 || regW !== 5'd0 || Wdat !== 32'd0) begin
                bad++;
                $display("FAIL reset_outputs: got we=%b r%0d=%h, required 0/0/0", RegWrite, regW, Wdat);
            end
        end
        resetn = 1'b1;
        push(5'd3, 32'h33);
        tick();
        p_valid = 1'b0;
        @(negedge clk);
        total++;
        if (RegWrite !== 1'b1 || regW !== 5'd3) begin
            bad++;
            $display("FAIL reset_first_write: got we=%b r%0d, required we=1 r3", RegWrite, regW);
        end
        tick();
    endtask

    task automatic test_single_write();
        p_valid = 1'b1; p_regW = 5'd5; p_dat = 32'hDEADBEEF;
        @(negedge clk);
        total++;
        if (p_ready !== 1'b1) begin
            bad++;
            $display("FAIL single_p_ready: got %b, required 1", p_ready);
        end
        push(5'd5, 32'hDEADBEEF);
        tick();
        p_valid = 1'b0;
        tick();
        @(negedge clk);
        total++;
        if (RegWrite !== 1'b0) begin
            bad++;
            $display("FAIL single_one_shot: got we=%b, required 0", RegWrite);
        end
        tick();
    endtask

    task automatic test_m_write();
        m_valid = 1'b1; m_regW = 5'd9; m_dat = 32'h12345678;
        @(negedge clk);
        total++;
        if (m_ready !== 1'b1) begin
            bad++;
            $display("FAIL m_idle_ready: got %b, required 1", m_ready);
        end
        push(5'd9, 32'h12345678);
        tick();
        m_valid = 1'b0;
        tick();
    endtask

    // Continuous pipeline traffic to r1..r8 with m pending: 4 stalls, then a forced cycle.
    task automatic run_starve(input logic [4:0] m_reg, input logic [31:0] mdat);
        int k = 1;
        p_valid = 1'b1;
        m_valid = 1'b1; m_regW = m_reg; m_dat = mdat;
        for (int c = 1; c <= 9; c++) begin
            p_regW = 5'(k);
            p_dat  = 32'(256 + k);
            @(negedge clk);
            total++;
            if (c == 5) begin
                if (p_ready !== 1'b0 || m_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL starve_force c%0d: got p_rdy=%b m_rdy=%b, required 0/1", c, p_ready, m_ready);
                end
                push(m_reg, mdat);
            end else begin
                if (p_ready !== 1'b1 || (c < 5 && m_ready !== 1'b0)) begin
                    bad++;
                    $display("FAIL starve_normal c%0d: got p_rdy=%b m_rdy=%b, required 1/0", c, p_ready, m_ready);
                end
                push(5'(k), 32'(256 + k));
                k++;
            end
            tick();
            if (c == 5) m_valid = 1'b0;
        end
        p_valid = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        run_starve(5'd20, 32'hABCD0014);
    endtask

    task automatic test_waw();
        p_valid = 1'b1; p_regW = 5'd7; p_dat = 32'h1;
        m_valid = 1'b1; m_regW = 5'd7; m_dat = 32'h2;
        @(negedge clk);
        total++;
        if (p_ready !== 1'b1 || m_ready !== 1'b1) begin
            bad++;
            $display("FAIL waw_ready: got p_rdy=%b m_rdy=%b, required 1/1", p_ready, m_ready);
        end
        push(5'd7, 32'h1);
        tick();
        p_valid = 1'b0;
        m_valid = 1'b0;
        tick();
    endtask

    task automatic test_r0();
        p_valid = 1'b1; p_regW = 5'd0; p_dat = 32'hFFFF;
        @(negedge clk);
        total++;
        if (p_ready !== 1'b1) begin
            bad++;
            $display("FAIL r0_ready: got %b, required 1", p_ready);
        end
        tick();
        p_valid = 1'b0;
        @(negedge clk);
        total++;
        if (RegWrite !== 1'b0 || regW !== 5'd7 || Wdat !== 32'h1) begin
            bad++;
            $display("FAIL r0_discard: got we=%b r%0d=%h, required we=0 r7=1 held", RegWrite, regW, Wdat);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        p_valid = 1'b1; p_regW = 5'd10; p_dat = 32'hA0;
        @(negedge clk);
        push(5'd10, 32'hA0);
        tick();
        p_regW = 5'd11; p_dat = 32'hB0;
        m_valid = 1'b1; m_regW = 5'd12; m_dat = 32'hC0;
        @(negedge clk);
        total++;
        if (p_ready !== 1'b1 || m_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_conflict: got p_rdy=%b m_rdy=%b, required 1/0", p_ready, m_ready);
        end
        push(5'd11, 32'hB0);
        tick();
        p_valid = 1'b0;
        @(negedge clk);
        total++;
        if (m_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_m_after_idle: got %b, required 1", m_ready);
        end
        push(5'd12, 32'hC0);
        tick();
        m_valid = 1'b0;
        p_valid = 1'b1; p_regW = 5'd13; p_dat = 32'hD0;
        @(negedge clk);
        push(5'd13, 32'hD0);
        tick();
        p_valid = 1'b0;
        tick();
    endtask

    // Reset while m is partly starved must clear the wait count and issue nothing.
    task automatic test_mid_reset();
        p_valid = 1'b1; p_regW = 5'd2; p_dat = 32'h222;
        m_valid = 1'b1; m_regW = 5'd4; m_dat = 32'h444;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            push(5'd2, 32'h222);
            tick();
        end
        @(negedge clk);
        #1;
        resetn = 1'b0;
        @(negedge clk);
        total++;
        if (RegWrite !== 1'b0 || regW !== 5'd0 || Wdat !== 32'd0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got we=%b r%0d=%h, required 0/0/0", RegWrite, regW, Wdat);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        p_valid = 1'b0;
        m_valid = 1'b0;
        resetn  = 1'b1;
        tick();
        run_starve(5'd21, 32'h0BADF00D);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_m_write();
        test_starvation();
        test_waw();
        test_r0();
        test_back_to_back();
        test_mid_reset();
        repeat (3) tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_writes: got %0d outstanding, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
